// File: rtl/noc_recv_dma.sv
// NoC receive DMA: buffers flits from a router local port and writes packet payloads into RAM.
// Optional RECV_DEST_CHECK_EN drops packets whose header does not match ADDRESS and counts them.
module noc_recv_dma #(
    parameter int FLIT_WIDTH   = 16,
    parameter int MEMORY_WIDTH = 32,
    parameter int RAM_MSIZE    = 65536,
    parameter int FIFO_DEPTH   = 4,
    parameter int ADDRESS      = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    rx,
    input  logic [FLIT_WIDTH-1:0]   data_i,
    output logic                    credit_o,
    output logic [31:0]             mem_addr_out,
    output logic [MEMORY_WIDTH-1:0] mem_data_out,
    output logic                    mem_wb_out,
    input  logic [31:0]             recv_addr_in,
    input  logic                    recv_cmd_in,
    output logic [31:0]             recv_size_out,
    output logic [31:0]             recv_addr_out,
    output logic                    irq_recv_size_out,
    output logic                    irq_recv_hshk_out,
`ifdef RECV_DEST_CHECK_EN
    output logic [7:0]              drop_count_out,
`endif
    output logic [7:0]              state_recv_out
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [31:0]   RAM_MASK = 32'(RAM_MSIZE - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SIZE     = 3'd1;
    localparam logic [2:0] S_WAIT_CMD = 3'd2;
    localparam logic [2:0] S_PAYLOAD  = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;
`ifdef RECV_DEST_CHECK_EN
    localparam logic [2:0] S_DISC_SIZE = 3'd5;
    localparam logic [2:0] S_DISC_PAY  = 3'd6;
    localparam logic [31:0] NODE_ADDR  = 32'(ADDRESS);
`endif

    logic [FLIT_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]         rd_ptr, wr_ptr;
    logic [CW-1:0]         count, count_next;
    logic                  push, pop, empty;
    logic [FLIT_WIDTH-1:0] head;

    logic [2:0]            state;
    logic [FLIT_WIDTH-1:0] remaining;
    logic [FLIT_WIDTH-1:0] hi_flit;
    logic                  half;

    assign push  = rx && credit_o;
    assign empty = (count == '0);
    assign head  = fifo_mem[rd_ptr];

    // Pops happen only in states that consume flits; WAIT_CMD and DONE let the FIFO fill.
    always_comb begin
        pop = 1'b0;
        case (state)
            S_IDLE, S_SIZE, S_PAYLOAD: pop = !empty;
`ifdef RECV_DEST_CHECK_EN
            S_DISC_SIZE, S_DISC_PAY:   pop = !empty;
`endif
            default:                   pop = 1'b0;
        endcase
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= data_i;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            credit_o <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count_next;
            credit_o <= (count_next < DEPTH_C);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            remaining     <= '0;
            hi_flit       <= '0;
            half          <= 1'b0;
            recv_size_out <= '0;
            recv_addr_out <= '0;
            mem_addr_out  <= '0;
            mem_data_out  <= '0;
            mem_wb_out    <= 1'b0;
`ifdef RECV_DEST_CHECK_EN
            drop_count_out <= '0;
`endif
        end else begin
            mem_wb_out <= 1'b0;
            case (state)
                S_IDLE: if (pop) begin
`ifdef RECV_DEST_CHECK_EN
                    if (16'(head) != NODE_ADDR[15:0]) begin
                        state <= S_DISC_SIZE;
                        if (drop_count_out != 8'hFF) drop_count_out <= drop_count_out + 8'd1;
                    end else begin
                        state <= S_SIZE;
                    end
`else
                    state <= S_SIZE;
`endif
                end
                S_SIZE: if (pop) begin
                    recv_size_out <= 32'(head);
                    remaining     <= head;
                    state         <= S_WAIT_CMD;
                end
                S_WAIT_CMD: if (recv_cmd_in) begin
                    recv_addr_out <= recv_addr_in;
                    half          <= 1'b0;
                    state         <= (remaining == '0) ? S_DONE : S_PAYLOAD;
                end
                S_PAYLOAD: if (pop) begin
                    // First flit of a pair fills the upper half; an unpaired last flit is written with zero below.
                    if (!half) begin
                        hi_flit <= head;
                        if (remaining == 1) begin
                            mem_wb_out    <= 1'b1;
                            mem_addr_out  <= (recv_addr_out & RAM_MASK) >> 2;
                            mem_data_out  <= {head, {FLIT_WIDTH{1'b0}}};
                            recv_addr_out <= recv_addr_out + 32'd4;
                        end else begin
                            half <= 1'b1;
                        end
                    end else begin
                        half          <= 1'b0;
                        mem_wb_out    <= 1'b1;
                        mem_addr_out  <= (recv_addr_out & RAM_MASK) >> 2;
                        mem_data_out  <= {hi_flit, head};
                        recv_addr_out <= recv_addr_out + 32'd4;
                    end
                    remaining <= remaining - 1'b1;
                    if (remaining == 1) state <= S_DONE;
                end
                S_DONE: if (!recv_cmd_in) state <= S_IDLE;
`ifdef RECV_DEST_CHECK_EN
                S_DISC_SIZE: if (pop) begin
                    remaining <= head;
                    state     <= (head == '0) ? S_IDLE : S_DISC_PAY;
                end
                S_DISC_PAY: if (pop) begin
                    remaining <= remaining - 1'b1;
                    if (remaining == 1) state <= S_IDLE;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    assign irq_recv_size_out = (state == S_WAIT_CMD);
    assign irq_recv_hshk_out = (state == S_DONE);
    assign state_recv_out    = {5'b0, state};

endmodule

// File: tb/tb_noc_recv_dma.sv
// Directed bench for noc_recv_dma: packets, odd size, backpressure, wrap, reset, zero size, drop path.
module tb_noc_recv_dma;

    logic        clock;
    logic        reset;
    logic        rx;
    logic [15:0] data_i;
    logic        credit_o;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_data_out;
    logic        mem_wb_out;
    logic [31:0] recv_addr_in;
    logic        recv_cmd_in;
    logic [31:0] recv_size_out;
    logic [31:0] recv_addr_out;
    logic        irq_recv_size_out;
    logic        irq_recv_hshk_out;
    logic [7:0]  state_recv_out;
`ifdef RECV_DEST_CHECK_EN
    logic [7:0]  drop_count_out;
`endif

    int checks = 0;
    int errors = 0;

    logic [63:0] wr_q[$];
    logic [63:0] exp_q[$];
    int          wait_cnt;
    logic        irq_seen;

    noc_recv_dma #(.ADDRESS(32'h0101)) dut (
        .clock(clock), .reset(reset), .rx(rx), .data_i(data_i), .credit_o(credit_o),
        .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out), .mem_wb_out(mem_wb_out),
        .recv_addr_in(recv_addr_in), .recv_cmd_in(recv_cmd_in),
        .recv_size_out(recv_size_out), .recv_addr_out(recv_addr_out),
        .irq_recv_size_out(irq_recv_size_out), .irq_recv_hshk_out(irq_recv_hshk_out),
`ifdef RECV_DEST_CHECK_EN
        .drop_count_out(drop_count_out),
`endif
        .state_recv_out(state_recv_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (mem_wb_out) wr_q.push_back({mem_addr_out, mem_data_out});
        if (state_recv_out == 8'd2) wait_cnt++;
        if (irq_recv_size_out || irq_recv_hshk_out) irq_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] f);
        int n = 0;
        while (!credit_o && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) check("credit_timeout", 64'(credit_o), 64'd1);
        rx     = 1'b1;
        data_i = f;
        @(negedge clock);
        rx     = 1'b0;
    endtask

    task automatic wait_state(input string tag, input logic [7:0] s);
        int n = 0;
        while (state_recv_out !== s && n < 200) begin
            @(negedge clock);
            n++;
        end
        check(tag, 64'(state_recv_out), 64'(s));
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_count"}, 64'(wr_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < wr_q.size()) check($sformatf("%s_w%0d", tag, i), wr_q[i], exp_q[i]);
        end
        wr_q.delete();
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b0; rx = 1'b0; data_i = '0; recv_addr_in = '0; recv_cmd_in = 1'b0;
        wait_cnt = 0; irq_seen = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_state", 64'(state_recv_out), 64'd0);
        check("rst_credit", 64'(credit_o), 64'd1);
        check("rst_wb", 64'(mem_wb_out), 64'd0);
        check("rst_size", 64'(recv_size_out), 64'd0);
        check("rst_irqs", 64'({irq_recv_size_out, irq_recv_hshk_out}), 64'd0);
        reset = 1'b1;
        @(negedge clock);

        // basic packet
        send(16'h0101); send(16'd4);
        wait_state("basic_wait", 8'd2);
        check("basic_irq_size", 64'(irq_recv_size_out), 64'd1);
        check("basic_size", 64'(recv_size_out), 64'd4);
        send(16'h1111); send(16'h2222); send(16'h3333); send(16'h4444);
        check("basic_nowrite", 64'(wr_q.size()), 64'd0);
        recv_addr_in = 32'h4000_0100;
        recv_cmd_in  = 1'b1;
        wait_state("basic_done", 8'd4);
        @(negedge clock);
        check("basic_hshk", 64'(irq_recv_hshk_out), 64'd1);
        check("basic_irq_size_low", 64'(irq_recv_size_out), 64'd0);
        check("basic_addr_out", 64'(recv_addr_out), 64'h4000_0108);
        exp_q.push_back({32'h40, 32'h1111_2222});
        exp_q.push_back({32'h41, 32'h3333_4444});
        check_writes("basic");
        repeat (2) @(negedge clock);
        check("basic_hshk_hold", 64'(irq_recv_hshk_out), 64'd1);
        recv_cmd_in = 1'b0;
        wait_state("basic_idle", 8'd0);
        check("basic_hshk_low", 64'(irq_recv_hshk_out), 64'd0);

        // odd size
        send(16'h0101); send(16'd3);
        wait_state("odd_wait", 8'd2);
        check("odd_size", 64'(recv_size_out), 64'd3);
        recv_addr_in = 32'h0000_0200;
        recv_cmd_in  = 1'b1;
        send(16'hAAAA); send(16'hBBBB); send(16'hCCCC);
        wait_state("odd_done", 8'd4);
        @(negedge clock);
        exp_q.push_back({32'h80, 32'hAAAA_BBBB});
        exp_q.push_back({32'h81, 32'hCCCC_0000});
        check_writes("odd");
        recv_cmd_in = 1'b0;
        wait_state("odd_idle", 8'd0);

        // backpressure, with one flit offered while credit is low
        send(16'h0101); send(16'd6);
        wait_state("bp_wait", 8'd2);
        send(16'h0001); send(16'h0002); send(16'h0003); send(16'h0004);
        check("bp_credit_low", 64'(credit_o), 64'd0);
        rx = 1'b1; data_i = 16'hDEAD;
        @(negedge clock);
        rx = 1'b0;
        check("bp_credit_still_low", 64'(credit_o), 64'd0);
        check("bp_nowrite", 64'(wr_q.size()), 64'd0);
        check("bp_state", 64'(state_recv_out), 64'd2);
        recv_addr_in = 32'h0000_0300;
        recv_cmd_in  = 1'b1;
        send(16'h0005); send(16'h0006);
        wait_state("bp_done", 8'd4);
        @(negedge clock);
        exp_q.push_back({32'hC0, 32'h0001_0002});
        exp_q.push_back({32'hC1, 32'h0003_0004});
        exp_q.push_back({32'hC2, 32'h0005_0006});
        check_writes("bp");
        check("bp_credit_back", 64'(credit_o), 64'd1);
        recv_cmd_in = 1'b0;
        wait_state("bp_idle", 8'd0);

        // address wrap
        recv_addr_in = 32'h4000_FFFC;
        recv_cmd_in  = 1'b1;
        send(16'h0101); send(16'd4);
        send(16'h0A0A); send(16'h0B0B); send(16'h0C0C); send(16'h0D0D);
        wait_state("wrap_done", 8'd4);
        @(negedge clock);
        exp_q.push_back({32'h3FFF, 32'h0A0A_0B0B});
        exp_q.push_back({32'h0000, 32'h0C0C_0D0D});
        check_writes("wrap");
        check("wrap_addr_out", 64'(recv_addr_out), 64'h4001_0004);
        recv_cmd_in = 1'b0;
        wait_state("wrap_idle", 8'd0);

        // zero size with command already high: one WAIT_CMD cycle, no writes
        recv_cmd_in = 1'b1;
        wait_cnt = 0;
        send(16'h0101); send(16'd0);
        wait_state("zero_done", 8'd4);
        repeat (2) @(negedge clock);
        check("zero_wait_cycles", 64'(wait_cnt), 64'd1);
        check_writes("zero");
        recv_cmd_in = 1'b0;
        wait_state("zero_idle", 8'd0);

        // reset in the middle of a payload
        recv_addr_in = 32'h0000_0400;
        recv_cmd_in  = 1'b1;
        send(16'h0101); send(16'd4); send(16'h9999);
        wait_state("mid_payload", 8'd3);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_state", 64'(state_recv_out), 64'd0);
        check("mid_rst_credit", 64'(credit_o), 64'd1);
        check("mid_rst_irqs", 64'({irq_recv_size_out, irq_recv_hshk_out}), 64'd0);
        check("mid_rst_wb", 64'(mem_wb_out), 64'd0);
        check("mid_rst_size", 64'(recv_size_out), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        wr_q.delete();
        @(negedge clock);
        send(16'h0101); send(16'd2); send(16'h5555); send(16'h6666);
        wait_state("post_rst_done", 8'd4);
        @(negedge clock);
        check("post_rst_size", 64'(recv_size_out), 64'd2);
        exp_q.push_back({32'h100, 32'h5555_6666});
        check_writes("post_rst");
        recv_cmd_in = 1'b0;
        wait_state("post_rst_idle", 8'd0);

`ifdef RECV_DEST_CHECK_EN
        // header for another node is dropped silently
        irq_seen = 1'b0;
        send(16'h0202); send(16'd2); send(16'h7777); send(16'h8888);
        repeat (10) @(negedge clock);
        check("drop_state", 64'(state_recv_out), 64'd0);
        check("drop_count", 64'(drop_count_out), 64'd1);
        check("drop_irq", 64'(irq_seen), 64'd0);
        check_writes("drop");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $fatal(1, "FAIL global_timeout: observed running expected finished");
    end

endmodule

// File: doc/noc_recv_dma.md
NOC_RECV_DMA -- requirements
Module: noc_recv_dma

Interface
REQ-001 The block SHALL have parameter FLIT_WIDTH, default 16, flit width in bits.
REQ-002 The block SHALL have parameter MEMORY_WIDTH, default 32, RAM word width; it is fixed at 2*FLIT_WIDTH.
REQ-003 The block SHALL have parameter RAM_MSIZE, default 65536, RAM size in bytes (power of two).
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, ingress flit buffer depth (power of two, at least 2).
REQ-005 The block SHALL have parameter ADDRESS, default 0, node address; bits [3:0] hold X and bits [11:8] hold Y.
REQ-006 The block SHALL have ports (name, direction, width, meaning):
- clock, in, 1, single clock, rising edge.
- reset, in, 1, asynchronous active-low reset.
- rx, in, 1, flit valid from the router local port.
- data_i, in, FLIT_WIDTH, flit from the router local port.
- credit_o, out, 1, buffer space available; the router sends only while this is high.
- mem_addr_out, out, 32, RAM word address.
- mem_data_out, out, MEMORY_WIDTH, RAM write data.
- mem_wb_out, out, 1, RAM write strobe, one cycle per word.
- recv_addr_in, in, 32, destination byte address.
- recv_cmd_in, in, 1, CPU accept level.
- recv_size_out, out, 32, latched payload flit count.
- recv_addr_out, out, 32, current write byte address.
- irq_recv_size_out, out, 1, packet-size-available interrupt.
- irq_recv_hshk_out, out, 1, packet-complete interrupt.
- state_recv_out, out, 8, FSM state encoding.

Function
REQ-007 The block SHALL accept a flit into the FIFO on a rising edge where rx and credit_o are both high.
REQ-008 credit_o SHALL be registered and high iff FIFO occupancy is below FIFO_DEPTH.
- If rx is high while credit_o is low, the flit SHALL be ignored.
REQ-009 The packet format SHALL be: header flit, then size flit N, then N payload flits.
REQ-010 The FSM SHALL have states IDLE=0, SIZE=1, WAIT_CMD=2, PAYLOAD=3, DONE=4, with these transitions:
- IDLE pops the header and goes to SIZE.
- SIZE pops N, latches it into recv_size_out, and goes to WAIT_CMD.
- WAIT_CMD goes to PAYLOAD when recv_cmd_in is high, latching recv_addr_in into recv_addr_out.
- PAYLOAD goes to DONE after the last word is written.
- DONE goes to IDLE when recv_cmd_in is low.
REQ-011 The block SHALL pop at most one flit per cycle, and only in IDLE, SIZE and PAYLOAD.
- In WAIT_CMD the FIFO SHALL keep filling until full.
REQ-012 Payload packing SHALL be as follows:
- The first flit of a pair goes to the upper half of the word, the second to the lower half.
- For odd N, the final lower half SHALL be zero.
REQ-013 A word write SHALL occur as follows:
- mem_wb_out pulses for one cycle, on the cycle after the pop that completes the word (or after the last flit).
- mem_addr_out = (recv_addr_out & (RAM_MSIZE-1)) >> 2.
- recv_addr_out then advances by 4 (32-bit wrap), so word addresses wrap modulo RAM_MSIZE/4.
REQ-014 irq_recv_size_out SHALL be high exactly in WAIT_CMD.
REQ-015 irq_recv_hshk_out SHALL be high exactly in DONE.
REQ-016 When N=0, WAIT_CMD SHALL go directly to DONE on recv_cmd_in, with no writes.
REQ-017 If recv_cmd_in is already high on entry to WAIT_CMD, the FSM SHALL spend exactly one cycle there.
REQ-018 A recv_cmd_in drop during PAYLOAD SHALL be ignored.
REQ-019 Outside write cycles, mem_wb_out SHALL be 0; mem_addr_out and mem_data_out hold their last values.

Reset
REQ-020 While reset is low, the block SHALL asynchronously:
- clear the FIFO and set state to IDLE;
- set credit_o=1 and all other outputs to 0.
REQ-021 A reset mid-packet SHALL discard all buffered and partial data; the next flit after release is treated as a header.

Configuration
REQ-022 With RECV_DEST_CHECK_EN defined, the block SHALL compare the header with ADDRESS[15:0]. On mismatch:
- The block enters a discard path: it pops the size and N payload flits with no writes and no interrupts, then returns to IDLE.
- It increments an 8-bit saturating drop_count_out (extra port, reset 0).
REQ-023 Without RECV_DEST_CHECK_EN, the header SHALL be ignored, and neither the drop_count_out port nor the discard path SHALL exist.

Verification
REQ-024 Reset scenario: reset low mid-PAYLOAD -> state 0, credit_o=1, irqs 0, mem_wb_out 0; after release, flit 0x0101 is accepted as a header.
REQ-025 Basic packet scenario: header 0x0101, N=4, payload 1111/2222/3333/4444, recv_addr_in=0x40000100, cmd after irq_size -> writes 0x11112222@0x40 and 0x33334444@0x41, then irq_hshk=1 until cmd drops.
REQ-026 Odd-size scenario: N=3, payload AAAA/BBBB/CCCC -> writes 0xAAAABBBB then 0xCCCC0000; recv_size_out=3.
REQ-027 Backpressure scenario: cmd held low, router streams 6 payload flits -> credit_o low after 4 are buffered, no writes; cmd high -> all 6 flits written in order, with no loss.
REQ-028 Wrap-around scenario: recv_addr_in=0x4000FFFC, N=4 -> writes at word addresses 0x3FFF then 0x0000.
REQ-029 Destination-check scenario (macro defined, ADDRESS=0x0101): header 0x0202, N=2 -> no writes, no irqs, drop_count_out=1, FSM back in IDLE.
